// File: rtl/addr_mgr_pkg.sv
// Shared definitions for the multi-queue buffer address manager.
//   - mgr_state_t : two-state initialisation/run controller encoding
//   - cnt_width() : width of every occupancy counter (one bit wider than an
//                   address so a completely full list of 2**ADDR_WIDTH fits)
// The per-queue record (head, tail, count) depends on the instance's address
// width, so the top level declares it from cnt_width() and its own parameters.
package addr_mgr_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 12;
  localparam int CNT_EXTRA_BITS     = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mgr_state_t;

  function automatic int cnt_width(input int addr_width);
    return addr_width + CNT_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/addr_mgr_next_table.sv
// Next-pointer table shared by the free list and every queue's linked list.
// Ports:
//   clk                     clock
//   init_we, init_idx       initialisation write: next[idx] = idx + 1 (wraps)
//   rd_addr_a / rd_data_a   combinational read (free-list head successor)
//   rd_addr_b / rd_data_b   combinational read (dequeued head successor)
//   we_a, waddr_a, wdata_a  queue link write (append to a queue tail)
//   we_b, waddr_b, wdata_b  free-list link write (return to free-list tail)
// The two run-time writes never target the same entry in one cycle.
module addr_mgr_next_table #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_idx,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-1:0] rd_data_b,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] waddr_a,
  input  logic [ADDR_WIDTH-1:0] wdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] waddr_b,
  input  logic [ADDR_WIDTH-1:0] wdata_b
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // NOTE: the table has no reset; the INIT sweep gives it defined contents,
  // which keeps a large array out of the reset network.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= init_idx + ADDR_WIDTH'(1);
    end else begin
      if (we_a) mem[waddr_a] <= wdata_a;
      if (we_b) mem[waddr_b] <= wdata_b;
    end
  end

endmodule

// File: rtl/addr_manager_mq.sv
// Packet-buffer address manager: one free list plus NUM_QUEUES linked-list
// queues threaded through a single next-pointer table. One enqueue (allocate
// free-list head, append to a queue) and one dequeue (pop a queue head, return
// it to the free list) per cycle, including both on the same queue.
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   s_axis_enq_en/_qid           enqueue request and target queue
//   s_axis_deq_en/_qid           dequeue request and source queue
//   m_axis_enq_ready/_addr       enqueue accepted / granted address
//   m_axis_deq_addr              head address of queue deq_qid
//   m_axis_q_empty/_q_count      per-queue empty flags / occupancy (q0 in LSBs)
//   m_axis_free_count            free-list occupancy
//   m_axis_almost_full           free count below THRESHOLD_ALMOST_FULL
//   m_axis_init_done             pointer table initialised
// Build option ADDR_MGR_ERR_CHK_EN adds m_axis_err[1:0], sticky until reset:
//   bit0 dequeue from an empty queue, bit1 enqueue while not ready.
module addr_manager_mq
  import addr_mgr_pkg::*;
#(
  parameter int ADDR_WIDTH            = ADDR_WIDTH_DEFAULT,
  parameter int ADDR_TABLE_DEPTH      = 2 ** ADDR_WIDTH,
  parameter int NUM_QUEUES            = 4,
  parameter int QID_WIDTH             = 2,
  parameter int THRESHOLD_ALMOST_FULL = 48
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    s_axis_enq_en,
  input  logic [QID_WIDTH-1:0]                    s_axis_enq_qid,
  input  logic                                    s_axis_deq_en,
  input  logic [QID_WIDTH-1:0]                    s_axis_deq_qid,
  output logic                                    m_axis_enq_ready,
  output logic [ADDR_WIDTH-1:0]                   m_axis_enq_addr,
  output logic [ADDR_WIDTH-1:0]                   m_axis_deq_addr,
  output logic [NUM_QUEUES-1:0]                   m_axis_q_empty,
  output logic [NUM_QUEUES*(ADDR_WIDTH+1)-1:0]    m_axis_q_count,
  output logic [ADDR_WIDTH:0]                     m_axis_free_count,
  output logic                                    m_axis_almost_full,
  output logic                                    m_axis_init_done
`ifdef ADDR_MGR_ERR_CHK_EN
  ,
  output logic [1:0]                              m_axis_err
`endif
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef struct packed {
    addr_t head;
    addr_t tail;
    cnt_t  cnt;
  } q_state_t;

  mgr_state_t state, state_nxt;
  addr_t      init_idx;
  logic       init_done;

  addr_t    fl_head, fl_tail;
  cnt_t     free_cnt;
  q_state_t qs [NUM_QUEUES];

  logic                  enq_fire, deq_fire;
  logic [NUM_QUEUES-1:0] enq_hit, deq_hit;
  addr_t                 deq_head, enq_next, deq_next;
  logic                  link_we, ret_we;

  // ---------------- initialisation controller ----------------
  assign init_done = (state == ST_RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of all the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_idx <= init_idx + addr_t'(1);
    end
  end

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_idx == addr_t'(ADDR_TABLE_DEPTH - 1))
      state_nxt = ST_RUN;
  end

  // ---------------- request qualification ----------------
  assign deq_head = qs[s_axis_deq_qid].head;
  assign enq_fire = s_axis_enq_en && m_axis_enq_ready;
  assign deq_fire = s_axis_deq_en && init_done && (qs[s_axis_deq_qid].cnt != '0);

  always_comb begin
    enq_hit = '0;
    deq_hit = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      enq_hit[i] = enq_fire && (s_axis_enq_qid == QID_WIDTH'(i));
      deq_hit[i] = deq_fire && (s_axis_deq_qid == QID_WIDTH'(i));
    end
  end

  // Appending to a non-empty queue links its old tail to the new address;
  // returning to a non-empty free list links the old free tail to it.
  assign link_we = enq_fire && (qs[s_axis_enq_qid].cnt != '0);
  assign ret_we  = deq_fire && (free_cnt != '0);

  addr_mgr_next_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (ADDR_TABLE_DEPTH)
  ) u_next_table (
    .clk       (clk),
    .init_we   (state == ST_INIT),
    .init_idx  (init_idx),
    .rd_addr_a (fl_head),
    .rd_data_a (enq_next),
    .rd_addr_b (deq_head),
    .rd_data_b (deq_next),
    .we_a      (link_we),
    .waddr_a   (qs[s_axis_enq_qid].tail),
    .wdata_a   (fl_head),
    .we_b      (ret_we),
    .waddr_b   (fl_tail),
    .wdata_b   (deq_head)
  );

  // ---------------- free list ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fl_head  <= '0;
      fl_tail  <= addr_t'(ADDR_TABLE_DEPTH - 1);
      free_cnt <= cnt_t'(ADDR_TABLE_DEPTH);
    end else begin
      // With one free entry left and a simultaneous return, the returned
      // address becomes the head directly; its link is not written yet.
      if (enq_fire)
        fl_head <= (deq_fire && free_cnt == cnt_t'(1)) ? deq_head : enq_next;
      else if (deq_fire && free_cnt == '0)
        fl_head <= deq_head;
      if (deq_fire) fl_tail <= deq_head;
      free_cnt <= free_cnt + cnt_t'(deq_fire) - cnt_t'(enq_fire);
    end
  end

  // ---------------- per-queue lists ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_QUEUES; i++) qs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (enq_hit[i]) qs[i].tail <= fl_head;
        // Popping the last entry while appending: the new address is the head,
        // since next[] of the popped entry is only being written this cycle.
        if (deq_hit[i])
          qs[i].head <= (enq_hit[i] && qs[i].cnt == cnt_t'(1)) ? fl_head : deq_next;
        else if (enq_hit[i] && qs[i].cnt == '0)
          qs[i].head <= fl_head;
        if (enq_hit[i] && !deq_hit[i]) qs[i].cnt <= qs[i].cnt + cnt_t'(1);
        else if (deq_hit[i] && !enq_hit[i]) qs[i].cnt <= qs[i].cnt - cnt_t'(1);
      end
    end
  end

  // ---------------- outputs ----------------
  assign m_axis_init_done   = init_done;
  assign m_axis_enq_ready   = init_done && (free_cnt != '0);
  assign m_axis_enq_addr    = fl_head;
  assign m_axis_deq_addr    = deq_head;
  assign m_axis_free_count  = free_cnt;
  assign m_axis_almost_full = (free_cnt < cnt_t'(THRESHOLD_ALMOST_FULL));

  always_comb begin
    m_axis_q_empty = '0;
    m_axis_q_count = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      m_axis_q_empty[i]          = (qs[i].cnt == '0);
      m_axis_q_count[i*CW +: CW] = qs[i].cnt;
    end
  end

`ifdef ADDR_MGR_ERR_CHK_EN
  logic [1:0] err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= '0;
    end else begin
      if (s_axis_deq_en && qs[s_axis_deq_qid].cnt == '0) err[0] <= 1'b1;
      if (s_axis_enq_en && !m_axis_enq_ready)            err[1] <= 1'b1;
    end
  end

  assign m_axis_err = err;
`endif

endmodule

// File: tb/tb_addr_manager_mq.sv
module tb_addr_manager_mq;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int NQ = 4;
  localparam int QW = 2;
  localparam int TH = 4;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  logic rstn;
  logic enq_en, deq_en;
  logic [QW-1:0] enq_qid, deq_qid;
  logic enq_ready;
  logic [AW-1:0] enq_addr, deq_addr;
  logic [NQ-1:0] q_empty;
  logic [NQ*CW-1:0] q_count;
  logic [CW-1:0] free_count;
  logic almost_full, init_done;
`ifdef ADDR_MGR_ERR_CHK_EN
  logic [1:0] err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  addr_manager_mq #(
    .ADDR_WIDTH(AW), .ADDR_TABLE_DEPTH(DEPTH), .NUM_QUEUES(NQ),
    .QID_WIDTH(QW), .THRESHOLD_ALMOST_FULL(TH)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .s_axis_enq_en      (enq_en),
    .s_axis_enq_qid     (enq_qid),
    .s_axis_deq_en      (deq_en),
    .s_axis_deq_qid     (deq_qid),
    .m_axis_enq_ready   (enq_ready),
    .m_axis_enq_addr    (enq_addr),
    .m_axis_deq_addr    (deq_addr),
    .m_axis_q_empty     (q_empty),
    .m_axis_q_count     (q_count),
    .m_axis_free_count  (free_count),
    .m_axis_almost_full (almost_full),
    .m_axis_init_done   (init_done)
`ifdef ADDR_MGR_ERR_CHK_EN
    ,
    .m_axis_err         (err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Directed vector: inputs for one cycle plus outputs expected before its edge.
  // -1 in an address field means the value is undefined there and not compared.
  typedef struct {
    bit enq; int eq; bit deq; int dq;
    int ready; int ea; int da; int free; int qcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit enq, int eq, bit deq, int dq,
                              int ready, int ea, int da, int free, int qcnt);
    vec_t v;
    v.enq = enq; v.eq = eq; v.deq = deq; v.dq = dq;
    v.ready = ready; v.ea = ea; v.da = da; v.free = free; v.qcnt = qcnt;
    return v;
  endfunction

  task automatic apply_row(input int idx, input vec_t v);
    enq_en = v.enq; enq_qid = QW'(v.eq); deq_en = v.deq; deq_qid = QW'(v.dq);
    @(negedge clk);
    check($sformatf("r%0d_ready", idx), enq_ready, v.ready);
    if (v.ea >= 0) check($sformatf("r%0d_enq_addr", idx), enq_addr, v.ea);
    if (v.da >= 0) check($sformatf("r%0d_deq_addr", idx), deq_addr, v.da);
    check($sformatf("r%0d_free", idx), free_count, v.free);
    check($sformatf("r%0d_qcnt", idx), q_count[v.dq*CW +: CW], v.qcnt);
    check($sformatf("r%0d_qempty", idx), q_empty[v.dq], v.qcnt == 0);
    check($sformatf("r%0d_afull", idx), almost_full, v.free < TH);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_enq_ready"}, enq_ready, 0);
    check({tag, "_free"}, free_count, DEPTH);
    check({tag, "_enq_addr"}, enq_addr, 0);
    check({tag, "_q_empty"}, q_empty, 4'hF);
    check({tag, "_q_count"}, q_count, 0);
    check({tag, "_afull"}, almost_full, 0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_init_c%0d", tag, i), init_done, i == DEPTH - 1);
    end
  endtask

  // Reference model: FIFO free list and FIFO queues of addresses.
  int fl[$];
  int qm[NQ][$];

  task automatic rand_cycle(input int enq_pct, input int deq_pct, input int n);
    logic [NQ*CW-1:0] exp_qc;
    logic [NQ-1:0] exp_em;
    int e_q, d_q, a, d;
    bit e, dd, do_e, do_d;
    e = ($urandom_range(99) < enq_pct);
    dd = ($urandom_range(99) < deq_pct);
    e_q = $urandom_range(NQ - 1);
    d_q = $urandom_range(NQ - 1);
    enq_en = e; enq_qid = QW'(e_q); deq_en = dd; deq_qid = QW'(d_q);
    @(negedge clk);
    exp_qc = '0;
    exp_em = '0;
    for (int i = 0; i < NQ; i++) begin
      exp_qc[i*CW +: CW] = CW'(qm[i].size());
      exp_em[i] = (qm[i].size() == 0);
    end
    check($sformatf("rnd%0d_init_done", n), init_done, 1);
    check($sformatf("rnd%0d_ready", n), enq_ready, fl.size() != 0);
    if (fl.size() != 0) check($sformatf("rnd%0d_enq_addr", n), enq_addr, fl[0]);
    if (qm[d_q].size() != 0) check($sformatf("rnd%0d_deq_addr", n), deq_addr, qm[d_q][0]);
    check($sformatf("rnd%0d_free", n), free_count, fl.size());
    check($sformatf("rnd%0d_q_count", n), q_count, exp_qc);
    check($sformatf("rnd%0d_q_empty", n), q_empty, exp_em);
    check($sformatf("rnd%0d_afull", n), almost_full, fl.size() < TH);
    do_e = e && (fl.size() != 0);
    do_d = dd && (qm[d_q].size() != 0);
    if (do_e) begin
      a = fl.pop_front();
      qm[e_q].push_back(a);
    end
    if (do_d) begin
      d = qm[d_q].pop_front();
      fl.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int list13[13];
    list13 = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 5};

    // --- directed table ---
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, -1, 16, 0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 1,  0, 15, 1));
    tbl.push_back(mk(1, 1, 0, 1, 1, 2,  0, 14, 2));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3,  0, 13, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3,  1, 14, 2));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3,  2, 15, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3, -1, 16, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3, -1, 16, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4,  3, 15, 1));
    tbl.push_back(mk(1, 2, 0, 2, 1, 5, -1, 14, 0));
    // q2 holds only 5: enqueue and dequeue q2 together
    tbl.push_back(mk(1, 2, 1, 2, 1, 6,  5, 13, 1));
    tbl.push_back(mk(0, 0, 0, 2, 1, 7,  6, 13, 1));
    // fill the remaining 13 free entries into q0
    for (int k = 0; k < 13; k++)
      tbl.push_back(mk(1, 0, 0, 0, 1, list13[k], 3, 13 - k, 2 + k));
    // full: enqueue refused, dequeue of 3 proceeds
    tbl.push_back(mk(1, 0, 1, 0, 0, -1, 3, 0, 15));
    // one free entry (3) plus simultaneous return of 4
    tbl.push_back(mk(1, 1, 1, 0, 1, 3, 4, 1, 14));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4, 3, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 4, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 4, 7, 2, 13));
    // dequeue from empty q3 is ignored
    tbl.push_back(mk(0, 0, 1, 3, 1, 4, -1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 3, 1, 4, -1, 2, 0));

    // --- reset and initialisation ---
    rstn = 1'b0; enq_en = 0; deq_en = 0; enq_qid = '0; deq_qid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    rstn = 1'b1;
    wait_init("por");
    check("post_init_free", free_count, DEPTH);
    check("post_init_enq_addr", enq_addr, 0);

    foreach (tbl[i]) apply_row(i, tbl[i]);

    // --- reset in the middle of traffic ---
    enq_en = 1; enq_qid = 2'd1; deq_en = 1; deq_qid = 2'd0;
    @(posedge clk); #2;
    rstn = 1'b0; enq_en = 0; deq_en = 0;
    #1;
    check_reset_state("mid");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    wait_init("mid");

`ifdef ADDR_MGR_ERR_CHK_EN
    deq_en = 1; deq_qid = 2'd3;
    @(posedge clk); #1;
    deq_en = 0;
    check("err_deq_empty", err, 2'b01);
`endif

    // --- randomized traffic against the model ---
    fl.delete();
    for (int i = 0; i < DEPTH; i++) fl.push_back(i);
    for (int i = 0; i < NQ; i++) qm[i].delete();
    for (int n = 0; n < 150; n++) rand_cycle(85, 20, n);
    for (int n = 150; n < 300; n++) rand_cycle(20, 85, n);
    for (int n = 300; n < 500; n++) rand_cycle(60, 60, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
